// File: rtl/ps2_mouse_sequencer.sv
// ps2_mouse_sequencer
// Sits between the PS/2 byte transceiver and the game logic. After reset it
// sends the reset command (0xFF) to the mouse and handles the ACK, the
// self-test result (0xAA) and the device ID (0x00). It then sends the enable
// command (0xF4) and handles its ACK. Once the mouse is streaming, it builds
// 3-byte movement packets into dx/dy/buttons words with a one-cycle strobe.
//
// Ports
//   CLOCK                         system clock, rising edge
//   reset                         asynchronous active-high reset
//   received_data[7:0]            byte from the transceiver
//   received_data_en              one-cycle strobe per received byte
//   command_was_sent              transceiver: the command byte was accepted
//   error_communication_timed_out transceiver: the command send failed
//   the_command[7:0]              command byte to the transceiver
//   send_command                  one-cycle command request strobe
//   packet_valid                  one-cycle strobe: packet outputs updated
//   dx[8:0], dy[8:0]              signed movement {sign, byte}
//   buttons[2:0]                  {middle, right, left}
//   overflow[1:0]                 {y_ovf, x_ovf}
//   ready                         high while streaming
//   init_error                    high once initialisation has given up
//   resync_count[7:0]             saturating count of discarded bytes/packets
//
// state        | meaning
// SEND_RST     | issue 0xFF
// WAIT_CMD_RST | wait for the transceiver to deliver 0xFF
// WAIT_ACK_RST | wait for 0xFA after 0xFF
// WAIT_BAT     | wait for the self-test result 0xAA
// WAIT_ID      | wait for device ID 0x00
// SEND_EN      | issue 0xF4
// WAIT_CMD_EN  | wait for the transceiver to deliver 0xF4
// WAIT_ACK_EN  | wait for 0xFA after 0xF4
// STREAM       | assemble movement packets
// ERROR        | retries exhausted, stays here until reset
module ps2_mouse_sequencer #(
  parameter int unsigned RESP_TIMEOUT = 25_000_000,
  parameter int unsigned BAT_TIMEOUT  = 100_000_000,
  parameter int unsigned PKT_GAP      = 100_000,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       CLOCK,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  input  logic       command_was_sent,
  input  logic       error_communication_timed_out,
  output logic [7:0] the_command,
  output logic       send_command,
  output logic       packet_valid,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic [2:0] buttons,
  output logic [1:0] overflow,
  output logic       ready,
  output logic       init_error,
  output logic [7:0] resync_count
);

  typedef enum logic [3:0] {
    SEND_RST, WAIT_CMD_RST, WAIT_ACK_RST, WAIT_BAT, WAIT_ID,
    SEND_EN, WAIT_CMD_EN, WAIT_ACK_EN, STREAM, ERROR
  } state_t;

  // The timer is a down-counter loaded with limit-1 on entry, so that
  // terminal count (zero) falls on the limit-th cycle spent in the state.
  localparam logic [31:0] RESP_LD  = RESP_TIMEOUT - 32'd1;
  localparam logic [31:0] BAT_LD   = BAT_TIMEOUT - 32'd1;
  localparam logic [31:0] GAP_LD   = PKT_GAP - 32'd1;
  localparam logic [7:0]  LAST_TRY = 8'(MAX_RETRY - 1);

  state_t      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  rst_att_q, rst_att_d;
  logic [7:0]  en_att_q, en_att_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        send_q, send_d;
  logic        pv_q, pv_d;
  logic [8:0]  dx_q, dx_d;
  logic [8:0]  dy_q, dy_d;
  logic [2:0]  btn_q, btn_d;
  logic [1:0]  ovf_q, ovf_d;
  logic [7:0]  resync_q, resync_d;
  logic [7:0]  b0_q, b0_d;
  logic [7:0]  b1_q, b1_d;
  logic [1:0]  idx_q, idx_d;

  logic        tmo;
  logic        rst_fail;
  logic        en_fail;
  logic        gap_exp;
  logic [1:0]  res_inc;
  logic [8:0]  res_sum;

  assign tmo = (timer_q == 32'd0);

  // State register
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) state_q <= SEND_RST;
    else       state_q <= state_d;
  end

  // Next-state logic. A timeout takes priority over a byte in the same cycle.
  always_comb begin
    state_d  = state_q;
    rst_fail = 1'b0;
    en_fail  = 1'b0;
    case (state_q)
      SEND_RST: state_d = WAIT_CMD_RST;
      WAIT_CMD_RST: begin
        if (command_was_sent)                   state_d  = WAIT_ACK_RST;
        else if (error_communication_timed_out) rst_fail = 1'b1;
      end
      WAIT_ACK_RST: begin
        if (tmo) rst_fail = 1'b1;
        else if (received_data_en) begin
          if (received_data == 8'hFA) state_d = WAIT_BAT;
          else if (received_data == 8'hFE || received_data == 8'hFC) rst_fail = 1'b1;
        end
      end
      WAIT_BAT: begin
        if (tmo) rst_fail = 1'b1;
        else if (received_data_en) begin
          if (received_data == 8'hAA)      state_d  = WAIT_ID;
          else if (received_data == 8'hFC) rst_fail = 1'b1;
        end
      end
      WAIT_ID: begin
        if (tmo) rst_fail = 1'b1;
        else if (received_data_en) begin
          if (received_data == 8'h00) state_d  = SEND_EN;
          else                        rst_fail = 1'b1;
        end
      end
      SEND_EN: state_d = WAIT_CMD_EN;
      WAIT_CMD_EN: begin
        if (command_was_sent)                   state_d = WAIT_ACK_EN;
        else if (error_communication_timed_out) en_fail = 1'b1;
      end
      WAIT_ACK_EN: begin
        if (tmo) en_fail = 1'b1;
        else if (received_data_en) begin
          if (received_data == 8'hFA) state_d = STREAM;
          else if (received_data == 8'hFE || received_data == 8'hFC) en_fail = 1'b1;
        end
      end
      STREAM:  state_d = STREAM;
      ERROR:   state_d = ERROR;
      default: state_d = SEND_RST;
    endcase
    if (rst_fail) state_d = (rst_att_q == LAST_TRY) ? ERROR : SEND_RST;
    if (en_fail)  state_d = (en_att_q == LAST_TRY) ? ERROR : SEND_EN;
  end

  // Output / datapath next values
  always_comb begin
    cmd_d     = cmd_q;
    send_d    = 1'b0;
    pv_d      = 1'b0;
    dx_d      = dx_q;
    dy_d      = dy_q;
    btn_d     = btn_q;
    ovf_d     = ovf_q;
    b0_d      = b0_q;
    b1_d      = b1_q;
    idx_d     = idx_q;
    rst_att_d = rst_att_q;
    en_att_d  = en_att_q;
    timer_d   = tmo ? timer_q : timer_q - 32'd1;
    gap_exp   = 1'b0;
    res_inc   = 2'd0;

    case (state_q)
      SEND_RST: begin
        cmd_d  = 8'hFF;
        send_d = 1'b1;
      end
      SEND_EN: begin
        cmd_d  = 8'hF4;
        send_d = 1'b1;
      end
      WAIT_ID:     if (state_d == SEND_EN) rst_att_d = 8'd0;
      WAIT_ACK_EN: if (state_d == STREAM)  en_att_d  = 8'd0;
      STREAM: begin
        // A stalled partial packet is dropped; a byte arriving in the same
        // cycle is treated as the start of a new packet.
        gap_exp = (idx_q != 2'd0) && tmo;
        if (gap_exp) begin
          idx_d   = 2'd0;
          res_inc = 2'd1;
        end
        if (received_data_en) begin
          case (gap_exp ? 2'd0 : idx_q)
            2'd0: begin
              if (received_data[3]) begin
                b0_d    = received_data;
                idx_d   = 2'd1;
                timer_d = GAP_LD;
              end else begin
                res_inc = res_inc + 2'd1;
              end
            end
            2'd1: begin
              b1_d    = received_data;
              idx_d   = 2'd2;
              timer_d = GAP_LD;
            end
            default: begin
              dx_d  = {b0_q[4], b1_q};
              dy_d  = {b0_q[5], received_data};
              btn_d = b0_q[2:0];
              ovf_d = b0_q[7:6];
              pv_d  = 1'b1;
              idx_d = 2'd0;
            end
          endcase
        end
      end
      default: ;
    endcase

    if (rst_fail) rst_att_d = rst_att_q + 8'd1;
    if (en_fail)  en_att_d  = en_att_q + 8'd1;

    if (state_d != state_q) begin
      case (state_d)
        WAIT_ACK_RST, WAIT_ACK_EN, WAIT_ID: timer_d = RESP_LD;
        WAIT_BAT:                           timer_d = BAT_LD;
        default:                            timer_d = GAP_LD;
      endcase
    end

    res_sum  = {1'b0, resync_q} + {7'd0, res_inc};
    resync_d = res_sum[8] ? 8'hFF : res_sum[7:0];
  end

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      timer_q   <= 32'd0;
      rst_att_q <= 8'd0;
      en_att_q  <= 8'd0;
      cmd_q     <= 8'h00;
      send_q    <= 1'b0;
      pv_q      <= 1'b0;
      dx_q      <= 9'd0;
      dy_q      <= 9'd0;
      btn_q     <= 3'd0;
      ovf_q     <= 2'd0;
      resync_q  <= 8'd0;
      b0_q      <= 8'd0;
      b1_q      <= 8'd0;
      idx_q     <= 2'd0;
    end else begin
      timer_q   <= timer_d;
      rst_att_q <= rst_att_d;
      en_att_q  <= en_att_d;
      cmd_q     <= cmd_d;
      send_q    <= send_d;
      pv_q      <= pv_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      btn_q     <= btn_d;
      ovf_q     <= ovf_d;
      resync_q  <= resync_d;
      b0_q      <= b0_d;
      b1_q      <= b1_d;
      idx_q     <= idx_d;
    end
  end

  assign the_command  = cmd_q;
  assign send_command = send_q;
  assign packet_valid = pv_q;
  assign dx           = dx_q;
  assign dy           = dy_q;
  assign buttons      = btn_q;
  assign overflow     = ovf_q;
  assign ready        = (state_q == STREAM);
  assign init_error   = (state_q == ERROR);
  assign resync_count = resync_q;

endmodule

// File: tb/tb_ps2_mouse_sequencer.sv
`timescale 1ns/1ps
module tb_ps2_mouse_sequencer;

  localparam int RESP  = 20;
  localparam int BAT   = 40;
  localparam int GAP   = 16;
  localparam int RETRY = 3;

  logic       CLOCK = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;
  logic       command_was_sent = 1'b0;
  logic       error_communication_timed_out = 1'b0;
  logic [7:0] the_command;
  logic       send_command;
  logic       packet_valid;
  logic [8:0] dx;
  logic [8:0] dy;
  logic [2:0] buttons;
  logic [1:0] overflow;
  logic       ready;
  logic       init_error;
  logic [7:0] resync_count;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_send = 0;
  int n_pv   = 0;

  always #5 CLOCK = ~CLOCK;

  ps2_mouse_sequencer #(
    .RESP_TIMEOUT(RESP), .BAT_TIMEOUT(BAT), .PKT_GAP(GAP), .MAX_RETRY(RETRY)
  ) dut (
    .CLOCK(CLOCK),
    .reset(reset),
    .received_data(received_data),
    .received_data_en(received_data_en),
    .command_was_sent(command_was_sent),
    .error_communication_timed_out(error_communication_timed_out),
    .the_command(the_command),
    .send_command(send_command),
    .packet_valid(packet_valid),
    .dx(dx),
    .dy(dy),
    .buttons(buttons),
    .overflow(overflow),
    .ready(ready),
    .init_error(init_error),
    .resync_count(resync_count)
  );

  always @(negedge CLOCK) begin
    if (send_command) n_send++;
    if (packet_valid) n_pv++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic pulse_byte(input logic [7:0] b);
    @(negedge CLOCK);
    received_data    = b;
    received_data_en = 1'b1;
    @(negedge CLOCK);
    received_data_en = 1'b0;
  endtask

  task automatic pulse_sent();
    @(negedge CLOCK);
    command_was_sent = 1'b1;
    @(negedge CLOCK);
    command_was_sent = 1'b0;
  endtask

  task automatic pulse_tmo();
    @(negedge CLOCK);
    error_communication_timed_out = 1'b1;
    @(negedge CLOCK);
    error_communication_timed_out = 1'b0;
  endtask

  // Waits (bounded) for the next send_command; reports found flag and byte.
  task automatic expect_send(input string tag, input logic [7:0] exp, output int waited);
    bit found;
    found  = 1'b0;
    waited = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge CLOCK);
      waited++;
      if (send_command) found = 1'b1;
    end
    chk(tag, 32'({found, the_command}), 32'({1'b1, exp}));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cmd"},    32'(the_command),  32'h0);
    chk({tag, "_send"},   32'(send_command), 32'h0);
    chk({tag, "_pv"},     32'(packet_valid), 32'h0);
    chk({tag, "_dx"},     32'(dx),           32'h0);
    chk({tag, "_dy"},     32'(dy),           32'h0);
    chk({tag, "_btn"},    32'(buttons),      32'h0);
    chk({tag, "_ovf"},    32'(overflow),     32'h0);
    chk({tag, "_ready"},  32'(ready),        32'h0);
    chk({tag, "_err"},    32'(init_error),   32'h0);
    chk({tag, "_resync"}, 32'(resync_count), 32'h0);
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    received_data_en = 1'b0;
    command_was_sent = 1'b0;
    error_communication_timed_out = 1'b0;
    tick(3);
    reset = 1'b0;
  endtask

  // Completes initialisation once 0xFF has been issued.
  task automatic finish_init(input string tag);
    int w;
    pulse_sent();
    pulse_byte(8'hFA);
    pulse_byte(8'hAA);
    pulse_byte(8'h00);
    expect_send({tag, "_f4"}, 8'hF4, w);
    pulse_sent();
    pulse_byte(8'hFA);
    tick(2);
    chk({tag, "_ready"}, 32'(ready), 32'h1);
  endtask

  task automatic pkt(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                     input logic [7:0] b2, input logic [8:0] edx, input logic [8:0] edy,
                     input logic [2:0] ebtn, input logic [1:0] eovf);
    pulse_byte(b0);
    tick(2);
    pulse_byte(b1);
    tick(2);
    pulse_byte(b2);
    chk({tag, "_pv"},  32'(packet_valid), 32'h1);
    chk({tag, "_dx"},  32'(dx),           32'(edx));
    chk({tag, "_dy"},  32'(dy),           32'(edy));
    chk({tag, "_btn"}, 32'(buttons),      32'(ebtn));
    chk({tag, "_ovf"}, 32'(overflow),     32'(eovf));
    tick(1);
    chk({tag, "_pv_off"}, 32'(packet_valid), 32'h0);
  endtask

  initial begin
    int w;
    int mark;
    int pv_mark;

    // Reset values, first command latency, normal initialisation
    tick(3);
    check_zero("rst");
    mark  = n_send;
    reset = 1'b0;
    expect_send("first_ff", 8'hFF, w);
    chk("first_ff_lat", 32'(w), 32'd1);
    finish_init("init");
    tick(5);
    chk("init_sends", 32'(n_send - mark), 32'd2);
    chk("init_err", 32'(init_error), 32'h0);

    // Packets
    pkt("p1", 8'h09, 8'h05, 8'hFB, 9'h005, 9'h0FB, 3'b001, 2'b00);
    pkt("p2", 8'h38, 8'hFE, 8'h02, 9'h1FE, 9'h102, 3'b000, 2'b00);
    pkt("p3", 8'hCF, 8'h10, 8'h20, 9'h010, 9'h020, 3'b111, 2'b11);
    pkt("p4", 8'hAA, 8'hFA, 8'h01, 9'h0FA, 9'h101, 3'b010, 2'b10);
    tick(10);
    chk("hold_dx", 32'(dx), 32'h0FA);

    // Resync: bad first byte, then a stalled partial packet
    pv_mark = n_pv;
    pulse_byte(8'h00);
    tick(2);
    chk("rs_bad0", 32'(resync_count), 32'd1);
    pulse_byte(8'h09);
    tick(2);
    pulse_byte(8'h05);
    tick(GAP + 4);
    chk("rs_gap", 32'(resync_count), 32'd2);
    chk("rs_nopv", 32'(n_pv - pv_mark), 32'd0);
    pkt("p5", 8'h09, 8'h01, 8'h02, 9'h001, 9'h002, 3'b001, 2'b00);

    // Gap boundary: one cycle short of expiry keeps the packet
    pulse_byte(8'h09);
    tick(GAP - 3);
    pulse_byte(8'h05);
    tick(2);
    pulse_byte(8'h02);
    chk("gb_in_pv", 32'(packet_valid), 32'h1);
    chk("gb_in_dx", 32'(dx), 32'h005);
    chk("gb_in_rs", 32'(resync_count), 32'd2);

    // Gap boundary: byte on the expiry cycle restarts the packet
    tick(2);
    pulse_byte(8'h09);
    tick(GAP - 2);
    pulse_byte(8'h0B);
    tick(2);
    chk("gb_ex_rs", 32'(resync_count), 32'd3);
    pulse_byte(8'h01);
    tick(2);
    pulse_byte(8'h02);
    chk("gb_ex_pv", 32'(packet_valid), 32'h1);
    chk("gb_ex_btn", 32'(buttons), 32'h3);
    chk("gb_ex_dx", 32'(dx), 32'h001);
    chk("gb_ex_dy", 32'(dy), 32'h002);

    // Async reset in the middle of a packet
    tick(2);
    pulse_byte(8'h09);
    tick(2);
    pulse_byte(8'h05);
    tick(1);
    #2 reset = 1'b1;
    #1 check_zero("amid");
    @(negedge CLOCK);
    reset = 1'b0;
    mark  = n_send;
    expect_send("amid_ff", 8'hFF, w);
    chk("amid_ff_lat", 32'(w), 32'd1);

    // Retries: transceiver send failure on 0xFF, then two NAKs on 0xF4
    pulse_tmo();
    expect_send("rt_ff2", 8'hFF, w);
    pulse_sent();
    pulse_byte(8'hFA);
    pulse_byte(8'hAA);
    pulse_byte(8'h00);
    expect_send("rt_f4a", 8'hF4, w);
    pulse_sent();
    pulse_byte(8'hFE);
    expect_send("rt_f4b", 8'hF4, w);
    pulse_sent();
    pulse_byte(8'hFE);
    expect_send("rt_f4c", 8'hF4, w);
    pulse_sent();
    pulse_byte(8'hFA);
    tick(5);
    chk("rt_ready", 32'(ready), 32'h1);
    chk("rt_sends", 32'(n_send - mark), 32'd5);
    chk("rt_err", 32'(init_error), 32'h0);

    // Response timeout on 0xFF, and a byte on the expiry cycle
    do_reset();
    expect_send("to_ff1", 8'hFF, w);
    pulse_sent();
    expect_send("to_ff2", 8'hFF, w);
    chk("to_lat", 32'(w), 32'(RESP + 1));
    pulse_sent();
    tick(RESP - 2);
    pulse_byte(8'hFA);
    expect_send("to_ff3", 8'hFF, w);
    chk("to_edge_lat", 32'(w), 32'd1);
    pulse_sent();
    tick(RESP - 3);
    pulse_byte(8'hFA);
    pulse_byte(8'hAA);
    pulse_byte(8'h00);
    expect_send("to_f4", 8'hF4, w);
    pulse_sent();
    pulse_byte(8'hFA);
    tick(2);
    chk("to_ready", 32'(ready), 32'h1);

    // Retries exhausted on 0xF4
    do_reset();
    expect_send("er_ff", 8'hFF, w);
    pulse_sent();
    pulse_byte(8'hFA);
    pulse_byte(8'hAA);
    pulse_byte(8'h00);
    for (int i = 0; i < RETRY; i++) begin
      expect_send("er_f4", 8'hF4, w);
      pulse_sent();
      pulse_byte(8'hFE);
    end
    tick(3);
    chk("er_flag", 32'(init_error), 32'h1);
    chk("er_ready", 32'(ready), 32'h0);
    mark = n_send;
    pulse_byte(8'hFA);
    tick(RESP * 3);
    chk("er_nosend", 32'(n_send - mark), 32'd0);
    chk("er_sticky", 32'(init_error), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_sequencer.md
# ps2_mouse_sequencer

Controller that sits between the PS/2 transceiver (byte-level send/receive engine) and the game logic. After reset it initialises the mouse with the host-to-device command sequence, handling ACKs, self-test and retries. It then assembles the 3-byte stream-mode packets into validated movement/button words with a one-cycle strobe. It owns the transceiver's command port; no other block issues mouse commands.

## Interface
Parameters:
- RESP_TIMEOUT, 25_000_000: cycles to wait for an ACK/ID byte (0.5 s at 50 MHz).
- BAT_TIMEOUT, 100_000_000: cycles to wait for self-test result 0xAA after reset ACK.
- PKT_GAP, 100_000: max cycles between bytes of one packet before resync.
- MAX_RETRY, 3: command attempts before entering ERROR.

Ports:
- CLOCK  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- received_data  in  8  byte from transceiver, valid when received_data_en.
- received_data_en  in  1  one-cycle strobe per received byte.
- command_was_sent  in  1  one-cycle strobe: command byte accepted by device.
- error_communication_timed_out  in  1  one-cycle strobe: command send failed.
- the_command  out  8  command byte to transceiver.
- send_command  out  1  one-cycle request strobe; the_command stable from that cycle until done/error.
- packet_valid  out  1  one-cycle strobe: dx/dy/buttons updated.
- dx  out  9  signed X movement {byte0[4], byte1}.
- dy  out  9  signed Y movement {byte0[5], byte2}.
- buttons  out  3  {middle, right, left} = byte0[2:0].
- overflow  out  2  {y_ovf, x_ovf} = byte0[7:6].
- ready  out  1  high while in STREAM.
- init_error  out  1  high while in ERROR.
- resync_count  out  8  saturating count of discarded bytes/packets.

## Operation
- States: SEND_RST, WAIT_CMD_RST, WAIT_ACK_RST, WAIT_BAT, WAIT_ID, SEND_EN, WAIT_CMD_EN, WAIT_ACK_EN, STREAM, ERROR.
- SEND_RST: the_command=0xFF, pulse send_command, go WAIT_CMD_RST. SEND_EN: same with 0xF4, go WAIT_CMD_EN.
- WAIT_CMD_*: command_was_sent -> matching WAIT_ACK_*; error_communication_timed_out -> retry.
- WAIT_ACK_*: 0xFA -> next (WAIT_BAT or STREAM); 0xFE or 0xFC or RESP_TIMEOUT expiry -> retry; any other byte ignored.
- WAIT_BAT: 0xAA -> WAIT_ID; 0xFC or BAT_TIMEOUT -> retry from SEND_RST. WAIT_ID: 0x00 -> SEND_EN; other byte or RESP_TIMEOUT -> retry from SEND_RST.
- Retry: attempt counter per command (reset and enable counted separately, cleared on success). Attempt MAX_RETRY failing -> ERROR. ERROR is sticky until reset.
- STREAM: 2-bit byte index. At index 0, byte with bit3=0 is discarded, resync_count+1, index stays 0. Byte 0 is latched; byte 1 is latched; byte 2 completes the packet and updates outputs, index->0.
- Gap counter cleared on each accepted byte; at PKT_GAP with index≠0 -> index=0, resync_count+1.
- Bytes in STREAM are never ACK-checked; 0xFA/0xAA arriving mid-stream is treated as packet data (0xAA at index 0 passes bit3 test).

## Timing
- Reset values: the_command=0x00, send_command=0, packet_valid=0, dx=dy=0, buttons=0, overflow=0, ready=0, init_error=0, resync_count=0, state=SEND_RST.
- First send_command asserted the first CLOCK edge after reset deasserts.
- packet_valid and the new dx/dy/buttons/overflow appear the cycle after the third byte's received_data_en; outputs hold until the next packet.
- Timeout counters start on the cycle entering the wait state; expiry is the cycle the count reaches the limit.
- Simultaneous received_data_en and timeout/gap expiry: the timeout wins. The byte is re-evaluated as index 0 (STREAM) or dropped (wait states).
- Strobes arriving in SEND_* states are ignored.
- Reset mid-operation aborts any packet or command immediately; the sequence restarts at SEND_RST.

## Test plan
- Normal init: transceiver acks 0xFF, device returns FA, AA, 00, then acks 0xF4 with FA -> exactly two send_command pulses (0xFF, 0xF4), ready=1, init_error=0.
- Packet: bytes 0x09, 0x05, 0xFB -> packet_valid one cycle after 3rd byte, buttons=3'b001, dx=+5 (9'h005), dy=9'h0FB (+251). Bytes 0x38, 0xFE, 0x02 -> dx=9'h1FE (-2), dy=9'h102 (-254).
- Resync: byte 0x00 in STREAM at index 0 -> discarded, resync_count=1. Two bytes then a PKT_GAP silence -> index reset, resync_count=2, no packet_valid.
- Retry: reply 0xFE to 0xF4 twice, then FA -> three 0xF4 sends, then STREAM. Reply 0xFE MAX_RETRY times -> init_error=1, no further send_command.
- Timeout: no ACK after 0xFF for RESP_TIMEOUT cycles -> 0xFF resent on the following cycle. A byte coinciding with expiry is ignored.
- Async reset asserted after byte 1 of a packet -> all outputs zero immediately; after release, the next send_command carries 0xFF.
